// File: rtl/sseg_frame_ctrl.sv
// Frame controller for the serial 7-seg path: shadow regs, periodic refresh, optional blink (SSEG_BLINK_EN).
// Write-to-start 2 cycles from IDLE; busy for SHIFT_CYCLES+2 cycles per frame, late writes/ticks coalesce into one follow-up frame.
module sseg_frame_ctrl #(
  parameter int REFRESH_DIV  = 500000,
  parameter int SHIFT_CYCLES = 160,
  parameter int BLINK_DIV    = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [31:0] wr_hexs,
  input  logic [7:0]  wr_points,
  input  logic [7:0]  wr_les,
  input  logic [7:0]  blink_mask,
  output logic [31:0] hexs,
  output logic [7:0]  points,
  output logic [7:0]  LEs,
  output logic        start,
  output logic        busy
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int SW = (SHIFT_CYCLES > 1) ? $clog2(SHIFT_CYCLES) : 1;
  localparam logic [RW-1:0] RMAX  = RW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] SLOAD = SW'(SHIFT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, START, SHIFT} state_t;

  state_t        state;
  logic [RW-1:0] rcnt;
  logic [SW-1:0] scnt;
  logic          tick;
  logic          dirty;
  logic          pend;
  logic [31:0]   sh_hexs;
  logic [7:0]    sh_points;
  logic [7:0]    sh_les;
  logic [7:0]    blink_les;

  assign tick = (rcnt == RMAX);

  always_ff @(posedge clk) begin
    if (rst) rcnt <= '0;
    else     rcnt <= tick ? '0 : rcnt + 1'b1;
  end

`ifdef SSEG_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BMAX = BW'(BLINK_DIV - 1);

  logic [BW-1:0] bcnt;
  logic          blink_off;

  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt      <= '0;
      blink_off <= 1'b0;
    end else if (tick) begin
      if (bcnt == BMAX) begin
        bcnt      <= '0;
        blink_off <= ~blink_off;
      end else begin
        bcnt <= bcnt + 1'b1;
      end
    end
  end

  assign blink_les = blink_mask & {8{blink_off}};
`else
  logic unused_blink;
  assign unused_blink = ^{blink_mask, BLINK_DIV[0]};
  assign blink_les    = 8'h00;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_hexs   <= '0;
      sh_points <= '0;
      sh_les    <= '0;
    end else if (wr_en) begin
      sh_hexs   <= wr_hexs;
      sh_points <= wr_points;
      sh_les    <= wr_les;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      scnt   <= '0;
      hexs   <= '0;
      points <= '0;
      LEs    <= 8'hFF;
      start  <= 1'b0;
      busy   <= 1'b0;
      dirty  <= 1'b1;
      pend   <= 1'b0;
    end else begin
      if (wr_en) dirty <= 1'b1;
      if (tick)  pend  <= 1'b1;
      case (state)
        IDLE: begin
          if (dirty | pend) begin
            state <= LOAD;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          // Shadow is sampled before this edge's write, so a same-cycle write keeps dirty for the next frame.
          hexs   <= sh_hexs;
          points <= sh_points;
          LEs    <= sh_les | blink_les;
          if (!wr_en) dirty <= 1'b0;
          if (!tick)  pend  <= 1'b0;
          start  <= 1'b1;
          state  <= START;
        end
        START: begin
          start <= 1'b0;
          scnt  <= SLOAD;
          state <= SHIFT;
        end
        SHIFT: begin
          if (scnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            scnt <= scnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sseg_frame_ctrl.sv
// Directed bench for sseg_frame_ctrl: frames expected by the stimulus are queued and checked on each start pulse.
module tb_sseg_frame_ctrl;

  localparam int RD = 16;
  localparam int SC = 4;
  localparam int BD = 2;

`ifdef SSEG_BLINK_EN
  localparam logic [7:0] BLINK_ON = 8'h81;
`else
  localparam logic [7:0] BLINK_ON = 8'h00;
`endif

  typedef struct packed {
    logic [31:0] h;
    logic [7:0]  p;
    logic [7:0]  l;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [31:0] wr_hexs;
  logic [7:0]  wr_points;
  logic [7:0]  wr_les;
  logic [7:0]  blink_mask;
  logic [31:0] hexs;
  logic [7:0]  points;
  logic [7:0]  LEs;
  logic        start;
  logic        busy;

  frame_t exp_q[$];
  int     edge_n  = 0;
  int     n_check = 0;
  int     n_pass  = 0;

  sseg_frame_ctrl #(
    .REFRESH_DIV (RD),
    .SHIFT_CYCLES(SC),
    .BLINK_DIV   (BD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_hexs   (wr_hexs),
    .wr_points (wr_points),
    .wr_les    (wr_les),
    .blink_mask(blink_mask),
    .hexs      (hexs),
    .points    (points),
    .LEs       (LEs),
    .start     (start),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_check++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h at edge %0d", tag, obs, exp, edge_n);
  endtask

  task automatic push(input logic [31:0] h, input logic [7:0] p, input logic [7:0] l);
    frame_t f;
    f.h = h;
    f.p = p;
    f.l = l;
    exp_q.push_back(f);
  endtask

  // Steps up to edge e, requiring no start pulse on the way.
  task automatic idle_to(input int e);
    while (edge_n < e) begin
      step();
      chk("no_start", 32'(start), 32'd0);
    end
  endtask

  // The very next edge must launch a frame matching the oldest queued expectation.
  task automatic frame(input string tag);
    frame_t f;
    step();
    chk({tag, "_start"}, 32'(start), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
    end else begin
      f = exp_q.pop_front();
      chk({tag, "_hexs"}, hexs, f.h);
      chk({tag, "_points"}, 32'(points), 32'(f.p));
      chk({tag, "_les"}, 32'(LEs), 32'(f.l));
    end
  endtask

  task automatic wr_step(input logic [31:0] h, input logic [7:0] p, input logic [7:0] l);
    wr_en     = 1'b1;
    wr_hexs   = h;
    wr_points = p;
    wr_les    = l;
    step();
    chk("wr_no_start", 32'(start), 32'd0);
    wr_en = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    wr_en      = 1'b0;
    wr_hexs    = '0;
    wr_points  = '0;
    wr_les     = '0;
    blink_mask = '0;

    repeat (3) step();
    chk("rst_les", 32'(LEs), 32'hFF);
    chk("rst_start", 32'(start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hexs", hexs, 32'd0);

    // First frame after release: LOAD at edge 1, start at edge 2.
    rst    = 1'b0;
    edge_n = 0;
    push(32'h0, 8'h00, 8'h00);
    idle_to(1);
    chk("load_busy", 32'(busy), 32'd1);
    frame("first");

    // Only the refresh tick (edge 16) triggers the next frame.
    push(32'h0, 8'h00, 8'h00);
    idle_to(17);
    frame("tick1");

    // Write from IDLE: sampled at 25, start at 27, held through SHIFT.
    idle_to(24);
    wr_step(32'h1234_ABCD, 8'h05, 8'h00);
    push(32'h1234_ABCD, 8'h05, 8'h00);
    idle_to(26);
    frame("wr_idle");
    for (int k = 0; k < SC; k++) begin
      step();
      chk("hold_hexs", hexs, 32'h1234_ABCD);
      chk("hold_points", 32'(points), 32'h05);
      chk("hold_les", 32'(LEs), 32'h00);
      chk("hold_busy", 32'(busy), 32'd1);
      chk("hold_start", 32'(start), 32'd0);
    end
    step();
    chk("end_busy", 32'(busy), 32'd0);
    push(32'h1234_ABCD, 8'h05, 8'h00);
    idle_to(33);
    frame("tick2");

    // Three writes during SHIFT collapse into one follow-up frame with the last value.
    wr_step(32'h1111_1111, 8'h11, 8'h00);
    wr_step(32'h2222_2222, 8'h22, 8'h00);
    wr_step(32'hDEAD_BEEF, 8'h5A, 8'h00);
    push(32'hDEAD_BEEF, 8'h5A, 8'h00);
    idle_to(39);
    chk("burst_busy_fall", 32'(busy), 32'd0);
    idle_to(40);
    frame("burst");
    idle_to(46);
    chk("burst_one_only", 32'(busy), 32'd0);
    push(32'hDEAD_BEEF, 8'h5A, 8'h00);
    idle_to(49);
    frame("tick3");

    // A write landing in the LOAD cycle rides in the next frame, not the current one.
    idle_to(55);
    wr_step(32'hCAFE_0000, 8'h3C, 8'h00);
    push(32'hCAFE_0000, 8'h3C, 8'h00);
    idle_to(57);
    wr_en     = 1'b1;
    wr_hexs   = 32'h0000_0001;
    wr_points = 8'h00;
    wr_les    = 8'h00;
    push(32'h0000_0001, 8'h00, 8'h00);
    frame("load_old");
    wr_en = 1'b0;
    idle_to(63);
    chk("load_gap_busy", 32'(busy), 32'd0);
    idle_to(64);
    frame("load_new");

    // Blink: blink_off flips on ticks at edges 96 and 128 (every BD ticks).
    blink_mask = 8'h81;
    push(32'h1, 8'h00, 8'h00);
    idle_to(81);
    frame("blink_a");
    push(32'h1, 8'h00, BLINK_ON);
    idle_to(97);
    frame("blink_b");
    push(32'h1, 8'h00, BLINK_ON);
    idle_to(113);
    frame("blink_c");
    push(32'h1, 8'h00, 8'h00);
    idle_to(129);
    frame("blink_d");

    // Reset in the middle of SHIFT aborts the frame.
    idle_to(131);
    rst = 1'b1;
    step();
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_les", 32'(LEs), 32'hFF);
    chk("midrst_start", 32'(start), 32'd0);
    chk("midrst_hexs", hexs, 32'd0);
    rst    = 1'b0;
    edge_n = 0;
    push(32'h0, 8'h00, 8'h00);
    idle_to(1);
    frame("post_rst");

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end

endmodule
